alu_cmd_pipe: RTL and testbench
===============================

# alu_cmd_pipe

Command issue and result capture stage wrapped around the combinational ALU. Accepts {a, b, opcode} commands over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. The FIFO head drives the ALU operand ports; the ALU result and flags are registered into an output slot with its own valid/ready handshake. Sticky carry/overflow status is maintained for software polling.

## Interface

Parameters:
- DEPTH, 4, command FIFO entries; power of two, >= 2
- WIDTH, 32, operand/result width; matches ALU

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  command present
- in_ready  out  1  FIFO can accept
- in_a  in  WIDTH  signed operand A
- in_b  in  WIDTH  signed operand B
- in_opcode  in  4  ALU opcode (0000 AND … 1101 SRA; 1110/1111 undefined)
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_opcode  out  4  to ALU opcode
- alu_result  in  WIDTH  from ALU
- alu_zero, alu_negative, alu_carryout, alu_overflow  in  1 each  from ALU
- out_valid  out  1  result slot full
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  registered result
- out_zero, out_negative, out_carryout, out_overflow  out  1 each  registered flags
- out_illegal  out  1  command had opcode 1110/1111
- count  out  $clog2(DEPTH+1)  FIFO occupancy
- sticky_carry, sticky_overflow  out  1 each  accumulated status
- sticky_clear  in  1  clears sticky bits

## Operation

- FIFO: circular buffer, wr/rd pointers wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- Push: in_valid && in_ready at an edge. in_ready = !reset && (count < DEPTH); it does not depend on a same-cycle pop.
- Head drive: when count > 0, alu_a/alu_b/alu_opcode = head entry. When empty: alu_a = 0, alu_b = 0, alu_opcode = 4'b1111.
- Issue (pop): count > 0 && (!out_valid || out_ready). On issue, the output slot loads alu_result, the four flags, and out_illegal = (head opcode >= 4'b1110), and out_valid is set.
- Drain: out_valid && out_ready with no issue in the same cycle clears out_valid. Data outputs hold their last value.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Sticky: on issue, sticky_carry |= alu_carryout and sticky_overflow |= alu_overflow. If sticky_clear is high in the same cycle, the clear is applied first, then the OR. The set therefore wins for the issuing command.
- Illegal opcodes are not dropped. The ALU default result passes through with out_illegal = 1.
- Reset (at any time, including mid-stream): FIFO flushed, count = 0, out_valid = 0, all out_* data/flags = 0, out_illegal = 0, sticky bits = 0, in_ready = 0 while reset is high. Commands in flight are discarded.

## Timing

- Latency: a command pushed at edge k into an empty FIFO with an empty slot drives alu_* after edge k. It is captured at edge k+1, so out_valid is high in cycle k+1..
- Throughput: one command per cycle when out_ready is held high.
- Backpressure: with out_ready = 0, the slot holds one result and the FIFO holds DEPTH commands. In total, DEPTH+1 commands are accepted before in_ready stays low.
- The ALU path is combinational within one cycle: FIFO storage → alu_* → alu_result → slot register.
- out_* is stable while out_valid && !out_ready.
- First push is possible on the first edge after reset deasserts.

## Test plan

- Single command: SUB a=5, b=4 into an idle block → out_valid asserted one cycle after accept; out_result = 1, out_zero = 0, out_illegal = 0.
- Stream of 3 with out_ready = 1: AND(1,0), OR(0,1), SLT(3,10) on consecutive cycles → results 0 (out_zero = 1), 1, 1 on consecutive cycles, in order; count never exceeds 1.
- Full/backpressure: out_ready = 0, in_valid held with 6 distinct MULT commands → exactly 5 accepted (count = 4, in_ready = 0). Releasing out_ready drains all 5 results in order and wraps the pointers; a 6th command is accepted on the first freed slot.
- Illegal opcode: a = 10, b = 10, opcode = 4'b1110 → out_result = 0, out_illegal = 1, out_zero = 1.
- Sticky: ADD a = 2147483647, b = 1 (ALU reports overflow) → sticky_overflow = 1, held through later non-overflowing commands. sticky_clear alone → 0. sticky_clear coincident with an overflowing issue → remains 1.
- Reset mid-operation: 3 commands queued and out_valid high, then reset for 1 cycle → out_valid = 0, count = 0, sticky = 0, all out_* = 0. The next command after reset produces the correct result.

Source files
------------

// File: rtl/alu_cmd_pipe_if.sv
// rtl/alu_cmd_pipe_if.sv - command/result bundle between a host, alu_cmd_pipe and the ALU
interface alu_cmd_pipe_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // command side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_opcode;

  // ALU operand/result side
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_negative;
  logic             alu_carryout;
  logic             alu_overflow;

  // result slot
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_negative;
  logic             out_carryout;
  logic             out_overflow;
  logic             out_illegal;

  // status
  logic [CNT_W-1:0] count;
  logic             sticky_carry;
  logic             sticky_overflow;
  logic             sticky_clear;

  // pipe side
  modport slave (
    input  in_valid, in_a, in_b, in_opcode,
    output in_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow,
    output out_valid, out_result, out_zero, out_negative, out_carryout, out_overflow, out_illegal,
    input  out_ready,
    output count, sticky_carry, sticky_overflow,
    input  sticky_clear
  );

  // host plus ALU side
  modport master (
    output in_valid, in_a, in_b, in_opcode,
    input  in_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow,
    input  out_valid, out_result, out_zero, out_negative, out_carryout, out_overflow, out_illegal,
    output out_ready,
    input  count, sticky_carry, sticky_overflow,
    output sticky_clear
  );
endinterface

// File: rtl/alu_cmd_pipe.sv
// rtl/alu_cmd_pipe.sv - command FIFO feeding a combinational ALU with a registered result slot
module alu_cmd_pipe #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  alu_cmd_pipe_if.slave bus
);
  localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CNT_W    = $clog2(DEPTH + 1);
  localparam logic [3:0] OP_IDLE  = 4'b1111;
  localparam logic [3:0] OP_FIRST_ILLEGAL = 4'b1110;

  // command storage
  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [3:0]       r_mem_op [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // result slot
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic             r_out_zero;
  logic             r_out_negative;
  logic             r_out_carryout;
  logic             r_out_overflow;
  logic             r_out_illegal;

  // sticky status
  logic             r_sticky_carry;
  logic             r_sticky_overflow;

  logic             w_empty;
  logic             w_can_push;
  logic             w_push;
  logic             w_issue;
  logic [3:0]       w_head_op;
  logic             w_sticky_carry_kept;
  logic             w_sticky_overflow_kept;

  assign w_empty    = (r_count == '0);
  // Acceptance looks only at occupancy, never at a same-cycle pop, so
  // in_ready carries no combinational path from out_ready.
  assign w_can_push = !reset && (r_count < CNT_W'(DEPTH));
  assign w_push     = bus.in_valid && w_can_push;
  assign w_issue    = !w_empty && (!r_out_valid || bus.out_ready);
  assign w_head_op  = r_mem_op[r_rd_ptr];

  // A clear in the issuing cycle is applied before the OR, so the new status survives.
  assign w_sticky_carry_kept    = r_sticky_carry    && !bus.sticky_clear;
  assign w_sticky_overflow_kept = r_sticky_overflow && !bus.sticky_clear;

  // Head entry drives the ALU; an empty FIFO presents zeros with an idle opcode.
  assign bus.alu_a      = w_empty ? '0 : r_mem_a[r_rd_ptr];
  assign bus.alu_b      = w_empty ? '0 : r_mem_b[r_rd_ptr];
  assign bus.alu_opcode = w_empty ? OP_IDLE : w_head_op;

  assign bus.in_ready        = w_can_push;
  assign bus.count           = r_count;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_result      = r_out_result;
  assign bus.out_zero        = r_out_zero;
  assign bus.out_negative    = r_out_negative;
  assign bus.out_carryout    = r_out_carryout;
  assign bus.out_overflow    = r_out_overflow;
  assign bus.out_illegal     = r_out_illegal;
  assign bus.sticky_carry    = r_sticky_carry;
  assign bus.sticky_overflow = r_sticky_overflow;

  // Write accepted commands into the circular buffer (storage needs no reset).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= bus.in_a;
      r_mem_b[r_wr_ptr]  <= bus.in_b;
      r_mem_op[r_wr_ptr] <= bus.in_opcode;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count follows push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Capture the ALU outcome on issue; a drain without issue only drops valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_zero     <= 1'b0;
      r_out_negative <= 1'b0;
      r_out_carryout <= 1'b0;
      r_out_overflow <= 1'b0;
      r_out_illegal  <= 1'b0;
    end else if (w_issue) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= bus.alu_result;
      r_out_zero     <= bus.alu_zero;
      r_out_negative <= bus.alu_negative;
      r_out_carryout <= bus.alu_carryout;
      r_out_overflow <= bus.alu_overflow;
      r_out_illegal  <= (w_head_op >= OP_FIRST_ILLEGAL);
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid    <= 1'b0;
    end
  end

  // Accumulate carry/overflow of every issued command until software clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky_carry    <= 1'b0;
      r_sticky_overflow <= 1'b0;
    end else begin
      r_sticky_carry    <= w_sticky_carry_kept    || (w_issue && bus.alu_carryout);
      r_sticky_overflow <= w_sticky_overflow_kept || (w_issue && bus.alu_overflow);
    end
  end
endmodule

// File: tb/tb_alu_cmd_pipe.sv
// tb/tb_alu_cmd_pipe.sv - directed self-checking bench for alu_cmd_pipe
module tb_alu_cmd_pipe;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_NAND = 4'b1010;
  localparam logic [3:0] OP_SLL  = 4'b1011;
  localparam logic [3:0] OP_SRL  = 4'b1100;
  localparam logic [3:0] OP_SRA  = 4'b1101;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  alu_cmd_pipe_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

  alu_cmd_pipe #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference combinational ALU
  logic [32:0] alu_tmp;
  always_comb begin
    alu_tmp          = '0;
    bus.alu_carryout = 1'b0;
    bus.alu_overflow = 1'b0;
    case (bus.alu_opcode)
      OP_AND:  alu_tmp[31:0] = bus.alu_a & bus.alu_b;
      OP_OR:   alu_tmp[31:0] = bus.alu_a | bus.alu_b;
      OP_XOR:  alu_tmp[31:0] = bus.alu_a ^ bus.alu_b;
      OP_NOR:  alu_tmp[31:0] = ~(bus.alu_a | bus.alu_b);
      OP_ADD: begin
        alu_tmp          = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        bus.alu_carryout = alu_tmp[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_tmp[31] != bus.alu_a[31]);
      end
      OP_SUB: begin
        alu_tmp          = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
        bus.alu_carryout = alu_tmp[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_tmp[31] != bus.alu_a[31]);
      end
      OP_SLT:  alu_tmp[31:0] = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      OP_SLTU: alu_tmp[31:0] = {31'd0, bus.alu_a < bus.alu_b};
      OP_MULT: alu_tmp[31:0] = bus.alu_a * bus.alu_b;
      OP_NAND: alu_tmp[31:0] = ~(bus.alu_a & bus.alu_b);
      OP_SLL:  alu_tmp[31:0] = bus.alu_a << bus.alu_b[4:0];
      OP_SRL:  alu_tmp[31:0] = bus.alu_a >> bus.alu_b[4:0];
      OP_SRA:  alu_tmp[31:0] = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      default: alu_tmp = '0;
    endcase
    bus.alu_result   = alu_tmp[31:0];
    bus.alu_zero     = (alu_tmp[31:0] == 32'd0);
    bus.alu_negative = alu_tmp[31];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_opcode = op;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0h exp 0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL rst_count got %0h exp 0", bus.count); end
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL rst_out_result got %0h exp 0", bus.out_result); end
    checks++; if (bus.alu_opcode !== 4'b1111) begin errors++; $display("FAIL rst_alu_opcode got %0h exp f", bus.alu_opcode); end
    checks++; if ({bus.sticky_carry, bus.sticky_overflow} !== 2'b00) begin errors++; $display("FAIL rst_sticky got %0h exp 0", {bus.sticky_carry, bus.sticky_overflow}); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %0h exp 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b0;
    push(32'd5, 32'd4, OP_SUB);
    checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count got %0h exp 1", bus.count); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0h exp 0", bus.out_valid); end
    checks++; if (bus.alu_a !== 32'd5 || bus.alu_opcode !== OP_SUB) begin errors++; $display("FAIL single_head got a=%0h op=%0h exp a=5 op=5", bus.alu_a, bus.alu_opcode); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0h exp 1", bus.out_valid); end
    checks++; if (bus.out_result !== 32'd1) begin errors++; $display("FAIL single_result got %0h exp 1", bus.out_result); end
    checks++; if (bus.out_zero !== 1'b0 || bus.out_illegal !== 1'b0) begin errors++; $display("FAIL single_flags got z=%0h ill=%0h exp 0 0", bus.out_zero, bus.out_illegal); end
    checks++; if (bus.sticky_carry !== 1'b1) begin errors++; $display("FAIL single_sticky_carry got %0h exp 1", bus.sticky_carry); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL single_count_after got %0h exp 0", bus.count); end
    bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0h exp 0", bus.out_valid); end
    checks++; if (bus.out_result !== 32'd1) begin errors++; $display("FAIL single_hold got %0h exp 1", bus.out_result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va  [3] = '{32'd1, 32'd0, 32'd3};
    logic [31:0] vb  [3] = '{32'd0, 32'd1, 32'd10};
    logic [3:0]  vop [3] = '{OP_AND, OP_OR, OP_SLT};
    logic [31:0] exp_r [3] = '{32'd0, 32'd1, 32'd1};
    logic        exp_z [3] = '{1'b1, 1'b0, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        bus.in_valid  = 1'b1;
        bus.in_a      = va[i];
        bus.in_b      = vb[i];
        bus.in_opcode = vop[i];
      end else begin
        bus.in_valid  = 1'b0;
      end
      tick();
      checks++; if (bus.count > 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0h exp <=1", i, bus.count); end
      if (i >= 1 && i <= 3) begin
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0h exp 1", i, bus.out_valid); end
        checks++; if (bus.out_result !== exp_r[i-1] || bus.out_zero !== exp_z[i-1]) begin errors++; $display("FAIL stream_result[%0d] got %0h z=%0h exp %0h z=%0h", i, bus.out_result, bus.out_zero, exp_r[i-1], exp_z[i-1]); end
      end
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got %0h exp 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] cmd_a   [6] = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] exp_mul [6] = '{32'd6, 32'd9, 32'd12, 32'd15, 32'd18, 32'd21};
    int   accepted;
    logic was_ready;
    accepted      = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_b      = 32'd3;
    bus.in_opcode = OP_MULT;
    for (int c = 0; c < 10; c++) begin
      bus.in_a  = cmd_a[accepted];
      was_ready = bus.in_ready;
      tick();
      if (was_ready) accepted++;
    end
    checks++; if (accepted != 5) begin errors++; $display("FAIL full_accepted got %0d exp 5", accepted); end
    checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count got %0h exp 4", bus.count); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0h exp 0", bus.in_ready); end
    bus.in_a      = cmd_a[5];
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp_mul[k]) begin errors++; $display("FAIL drain[%0d] got v=%0h r=%0h exp v=1 r=%0h", k, bus.out_valid, bus.out_result, exp_mul[k]); end
      was_ready = bus.in_ready;
      tick();
      if (was_ready && bus.in_valid) begin
        accepted++;
        bus.in_valid = 1'b0;
      end
    end
    checks++; if (accepted != 6) begin errors++; $display("FAIL drain_accepted got %0d exp 6", accepted); end
    checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL drain_empty got v=%0h cnt=%0h exp 0 0", bus.out_valid, bus.count); end
  endtask

  task automatic test_illegal();
    bus.out_ready = 1'b1;
    push(32'd10, 32'd10, 4'b1110);
    checks++; if (bus.alu_opcode !== 4'b1110) begin errors++; $display("FAIL ill_head got %0h exp e", bus.alu_opcode); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd0) begin errors++; $display("FAIL ill_result got v=%0h r=%0h exp 1 0", bus.out_valid, bus.out_result); end
    checks++; if (bus.out_illegal !== 1'b1 || bus.out_zero !== 1'b1) begin errors++; $display("FAIL ill_flags got ill=%0h z=%0h exp 1 1", bus.out_illegal, bus.out_zero); end
    push(32'd6, 32'd3, OP_XOR);
    tick();
    checks++; if (bus.out_illegal !== 1'b0 || bus.out_result !== 32'd5) begin errors++; $display("FAIL ill_next got ill=%0h r=%0h exp 0 5", bus.out_illegal, bus.out_result); end
    tick();
  endtask

  task automatic test_sticky();
    bus.out_ready    = 1'b1;
    bus.sticky_clear = 1'b1;
    tick();
    bus.sticky_clear = 1'b0;
    checks++; if ({bus.sticky_carry, bus.sticky_overflow} !== 2'b00) begin errors++; $display("FAIL sticky_clear0 got %0h exp 0", {bus.sticky_carry, bus.sticky_overflow}); end
    push(32'h7fff_ffff, 32'd1, OP_ADD);
    tick();
    checks++; if (bus.out_result !== 32'h8000_0000 || bus.out_negative !== 1'b1 || bus.out_overflow !== 1'b1) begin errors++; $display("FAIL sticky_add got r=%0h n=%0h v=%0h exp 80000000 1 1", bus.out_result, bus.out_negative, bus.out_overflow); end
    checks++; if (bus.sticky_overflow !== 1'b1 || bus.sticky_carry !== 1'b0) begin errors++; $display("FAIL sticky_set got v=%0h c=%0h exp 1 0", bus.sticky_overflow, bus.sticky_carry); end
    push(32'd1, 32'd1, OP_ADD);
    tick();
    checks++; if (bus.sticky_overflow !== 1'b1 || bus.out_overflow !== 1'b0 || bus.out_result !== 32'd2) begin errors++; $display("FAIL sticky_hold got s=%0h v=%0h r=%0h exp 1 0 2", bus.sticky_overflow, bus.out_overflow, bus.out_result); end
    bus.sticky_clear = 1'b1;
    tick();
    bus.sticky_clear = 1'b0;
    checks++; if (bus.sticky_overflow !== 1'b0) begin errors++; $display("FAIL sticky_clear got %0h exp 0", bus.sticky_overflow); end
    push(32'h7fff_ffff, 32'd1, OP_ADD);
    bus.sticky_clear = 1'b1;
    tick();
    bus.sticky_clear = 1'b0;
    checks++; if (bus.sticky_overflow !== 1'b1) begin errors++; $display("FAIL sticky_set_wins got %0h exp 1", bus.sticky_overflow); end
    tick();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    push(32'h7fff_ffff, 32'd1, OP_ADD);
    push(32'd1, 32'd2, OP_ADD);
    push(32'd3, 32'd4, OP_ADD);
    push(32'd5, 32'd6, OP_ADD);
    checks++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1 || bus.sticky_overflow !== 1'b1) begin errors++; $display("FAIL mid_pre got cnt=%0h v=%0h s=%0h exp 3 1 1", bus.count, bus.out_valid, bus.sticky_overflow); end
    reset = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL mid_rst got rdy=%0h v=%0h cnt=%0h exp 0 0 0", bus.in_ready, bus.out_valid, bus.count); end
    checks++; if (bus.sticky_overflow !== 1'b0 || bus.sticky_carry !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky got v=%0h c=%0h exp 0 0", bus.sticky_overflow, bus.sticky_carry); end
    checks++; if (bus.out_result !== 32'd0 || {bus.out_zero, bus.out_negative, bus.out_carryout, bus.out_overflow, bus.out_illegal} !== 5'd0) begin errors++; $display("FAIL mid_rst_out got r=%0h flags=%0h exp 0 0", bus.out_result, {bus.out_zero, bus.out_negative, bus.out_carryout, bus.out_overflow, bus.out_illegal}); end
    checks++; if (bus.alu_opcode !== 4'b1111 || bus.alu_a !== 32'd0) begin errors++; $display("FAIL mid_rst_head got op=%0h a=%0h exp f 0", bus.alu_opcode, bus.alu_a); end
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    push(32'd9, 32'd2, OP_SUB);
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd7 || bus.out_carryout !== 1'b1) begin errors++; $display("FAIL mid_after got v=%0h r=%0h c=%0h exp 1 7 1", bus.out_valid, bus.out_result, bus.out_carryout); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mid_after_count got %0h exp 0", bus.count); end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_a         = '0;
    bus.in_b         = '0;
    bus.in_opcode    = '0;
    bus.out_ready    = 1'b0;
    bus.sticky_clear = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_sticky();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
